// File: rtl/dds_stream_gen.sv
// Streaming DDS core: phase accumulator + offset, quarter-wave sine ROM, four waveform modes.
// Optional phase dithering via LFSR when DDS_DITHER_EN is defined.
module dds_stream_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_phase_rst,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [OUT_W-1:0]   result_out
);
    localparam int IDX_W  = LUT_AW + 2;
    localparam int STAGES = 2;
    localparam logic [1:0] MODE_SIN = 2'd0;
    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_SAW = 2'd2;
    localparam logic [1:0] MODE_COS = 2'd3;
    localparam logic [IDX_W-1:0] QTR_SHIFT = IDX_W'(1) << LUT_AW;
    localparam logic [OUT_W-1:0] POS_FS = OUT_W'((1 << (OUT_W-1)) - 1);
    localparam logic [OUT_W-1:0] NEG_FS = OUT_W'((1 << (OUT_W-1)) + 1);
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [1:0]         mode;
    } s1_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [1:0]         mode;
        logic               neg;
    } s2_t;

    // Half-sample offset makes the quarter-wave mirror exact.
    function automatic logic [OUT_W-1:0] rom_entry(input int k);
        real x;
        x = real'((1 << (OUT_W-1)) - 1) *
            $sin(PI / 2.0 * (real'(k) + 0.5) / real'(1 << LUT_AW));
        return OUT_W'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-1:0] rom [2**LUT_AW];
    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        assign rom[k] = rom_entry(k);
    end

    logic [PHASE_W-1:0] acc, ftw, poff, phase_in;
    logic [1:0]         mode;
    logic [STAGES:0]    vld_pipe;
    logic               adv, take;
    s1_t                s1;
    s2_t                s2;
    logic [IDX_W-1:0]   p;
    logic [LUT_AW-1:0]  rom_addr;
    logic [OUT_W-1:0]   rom_q, out_nxt;

    assign adv          = !(result_valid && !result_ready);
    assign take         = adv && enable;
    assign result_valid = vld_pipe[STAGES];

`ifdef DDS_DITHER_EN
    localparam int DW = PHASE_W - IDX_W;
    logic [15:0]        lfsr;
    logic [PHASE_W-1:0] dith;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else if (take) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Left-align the LFSR to the top of the bits dropped by index extraction.
    if (DW >= 16) begin : g_dith_wide
        assign dith = PHASE_W'(lfsr) << (DW - 16);
    end else begin : g_dith_narrow
        assign dith = PHASE_W'(lfsr >> (16 - DW));
    end

    assign phase_in = acc + poff + dith;
`else
    assign phase_in = acc + poff;
`endif

    // Config writes land regardless of backpressure; phase reset beats the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            ftw       <= '0;
            poff      <= '0;
            mode      <= MODE_SIN;
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            if (take) acc <= acc + ftw;
            if (cfg_valid && cfg_ready) begin
                ftw  <= cfg_ftw;
                poff <= cfg_poff;
                mode <= cfg_mode;
                if (cfg_phase_rst) acc <= '0;
            end
        end
    end

    always_comb begin
        p = s1.phase[PHASE_W-1 -: IDX_W];
        if (s1.mode == MODE_COS) p = p + QTR_SHIFT;
        rom_addr = p[LUT_AW] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
    end

    always_comb begin
        case (s2.mode)
            MODE_SQR: out_nxt = s2.phase[PHASE_W-1] ? NEG_FS : POS_FS;
            MODE_SAW: out_nxt = {~s2.phase[PHASE_W-1], s2.phase[PHASE_W-2 -: OUT_W-1]};
            default:  out_nxt = s2.neg ? -rom_q : rom_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe   <= '0;
            result_out <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], enable};
            if (vld_pipe[STAGES-1]) result_out <= out_nxt;
        end
    end

    // Datapath registers carry no reset so the ROM read can map onto block RAM.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (take) s1 <= '{phase: phase_in, mode: mode};
            s2    <= '{phase: s1.phase, mode: s1.mode, neg: p[IDX_W-1]};
            rom_q <= rom[rom_addr];
        end
    end

endmodule

// File: tb/tb_dds_stream_gen.sv
// Self-checking bench for dds_stream_gen: directed waveform checks plus randomized
// traffic against a sample-level reference model.
module tb_dds_stream_gen;
    localparam int PW = 32;
    localparam int OW = 16;
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          reset, enable, cfg_valid, cfg_phase_rst, result_ready;
    logic          cfg_ready, result_valid;
    logic [PW-1:0] cfg_ftw, cfg_poff;
    logic [1:0]    cfg_mode;
    logic [OW-1:0] result_out;

    always #5 clk = ~clk;

    dds_stream_gen #(.PHASE_W(PW), .LUT_AW(10), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw),
        .cfg_poff(cfg_poff), .cfg_mode(cfg_mode), .cfg_phase_rst(cfg_phase_rst),
        .result_valid(result_valid), .result_ready(result_ready), .result_out(result_out)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: each sample is a function of its phase and mode only.
    function automatic int ref_sample(input logic [31:0] ph, input logic [1:0] md);
        int  idx;
        real x;
        case (md)
            2'd1: return ph[31] ? -32767 : 32767;
            2'd2: return int'(ph[31:16]) - 32768;
            default: begin
                idx = int'(ph[31:20]);
                if (md == 2'd3) idx = (idx + 1024) % 4096;
                x = 32767.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 4096.0);
                return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
            end
        endcase
    endfunction

    logic [31:0] m_acc, m_ftw, m_poff;
    logic [1:0]  m_mode;
    bit          m_rdy;
    bit          m_v [3];
    int          m_s [3];
    bit          cur_v;
    int          cur_out;
    int          got_q [$];
    int          pat [4] = '{25, 32767, -25, -32767};

    task automatic model_edge();
        bit adv;
        if (cur_v && result_ready && !reset) got_q.push_back(cur_out);
        if (reset) begin
            m_acc = '0; m_ftw = '0; m_poff = '0; m_mode = 2'd0; m_rdy = 0;
            m_v = '{0, 0, 0};
        end else begin
            adv = !(m_v[2] && !result_ready);
            if (adv) begin
                m_v[2] = m_v[1]; m_s[2] = m_s[1];
                m_v[1] = m_v[0]; m_s[1] = m_s[0];
                m_v[0] = enable;
                if (enable) begin
                    m_s[0] = ref_sample(m_acc + m_poff, m_mode);
                    m_acc  = m_acc + m_ftw;
                end
            end
            if (cfg_valid && m_rdy) begin
                m_ftw = cfg_ftw; m_poff = cfg_poff; m_mode = cfg_mode;
                if (cfg_phase_rst) m_acc = '0;
            end
            m_rdy = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cfg_ready", int'(cfg_ready), int'(m_rdy));
        chk("valid", int'(result_valid), int'(m_v[2]));
        if (m_v[2]) chk("sample", int'($signed(result_out)), m_s[2]);
        cur_v   = result_valid;
        cur_out = int'($signed(result_out));
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] po, input logic [1:0] md, input logic pr);
        cfg_ftw = f; cfg_poff = po; cfg_mode = md; cfg_phase_rst = pr; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        enable = 1'b0; result_ready = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        int hold;
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_phase_rst = 1'b0;
        result_ready = 1'b1; cfg_ftw = '0; cfg_poff = '0; cfg_mode = 2'd0;
        cur_v = 0; cur_out = 0;

        // Reset held, then released
        repeat (5) begin
            step();
            chk("rst_out", int'(result_out), 0);
        end
        reset = 1'b0;
        step();
        chk("cfg_ready_after_rst", int'(cfg_ready), 1);

        // Sine stream, latency and quarter-cycle pattern
        got_q.delete();
        cfg(32'h4000_0000, 32'h0, 2'd0, 1'b1);
        enable = 1'b1;
        step(); chk("lat1", int'(result_valid), 0);
        step(); chk("lat2", int'(result_valid), 0);
        step(); chk("lat3", int'(result_valid), 1);
        chk("first_sine", int'($signed(result_out)), 25);
        repeat (10) step();

        // Backpressure hold
        hold = cur_out;
        result_ready = 1'b0;
        repeat (7) begin
            step();
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_out", int'($signed(result_out)), hold);
        end
        result_ready = 1'b1;
        repeat (8) step();
        chk("sine_count", int'(got_q.size() > 12), 1);
        foreach (got_q[i]) chk($sformatf("sine[%0d]", i), got_q[i], pat[i % 4]);

        // Cosine
        drain(); got_q.delete();
        cfg(32'h4000_0000, 32'h0, 2'd3, 1'b1);
        enable = 1'b1; repeat (6) step();
        drain();
        chk("cos_count", got_q.size(), 6);
        foreach (got_q[i]) chk($sformatf("cos[%0d]", i), got_q[i], pat[(i + 1) % 4]);

        // Square
        got_q.delete();
        cfg(32'h2000_0000, 32'h0, 2'd1, 1'b1);
        enable = 1'b1; repeat (12) step();
        drain();
        chk("sqr_count", got_q.size(), 12);
        foreach (got_q[i]) chk($sformatf("sqr[%0d]", i), got_q[i], ((i % 8) < 4) ? 32767 : -32767);

        // Sawtooth across one full wrap
        got_q.delete();
        cfg(32'h0100_0000, 32'h0, 2'd2, 1'b1);
        enable = 1'b1; repeat (260) step();
        drain();
        chk("saw_count", got_q.size(), 260);
        foreach (got_q[i]) chk($sformatf("saw[%0d]", i), got_q[i], -32768 + 256 * (i % 256));

        // Mid-stream reconfig: samples 0..5 taken before the new offset applies
        got_q.delete();
        cfg(32'h4000_0000, 32'h0, 2'd0, 1'b1);
        enable = 1'b1; repeat (5) step();
        cfg(32'h4000_0000, 32'h8000_0000, 2'd0, 1'b0);
        repeat (6) step();
        drain();
        chk("reconf_count", got_q.size(), 12);
        foreach (got_q[i]) chk($sformatf("reconf[%0d]", i), got_q[i], (i <= 5) ? pat[i % 4] : -pat[i % 4]);

        // Reset mid-stream
        enable = 1'b1; repeat (4) step();
        reset = 1'b1; step();
        chk("rst_mid_valid", int'(result_valid), 0);
        reset = 1'b0; step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            reset         = ($urandom_range(0, 199) == 0);
            cfg_valid     = ($urandom_range(0, 9) == 0);
            cfg_mode      = 2'($urandom_range(0, 3));
            cfg_ftw       = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 15) << 24);
            cfg_poff      = $urandom;
            cfg_phase_rst = 1'($urandom_range(0, 1));
            enable        = ($urandom_range(0, 9) < 8);
            result_ready  = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
